debug_frame_rx: RTL and testbench

DEBUG_FRAME_RX -- requirements
Module: debug_frame_rx

---
 rtl/debug_frame_rx.sv | 98 +++++++++
 tb/tb_debug_frame_rx.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/debug_frame_rx.sv
// debug_frame_rx: receives SYNC(A5) ADDR D0..D7 CHK frames from a UART FIFO and publishes good frames
// Ports: clk, reset (sync, active-high); r_data/rx_empty FIFO head and empty flag; rd_uart pops the FIFO;
// set_addr/set_data last good frame, set_valid new-frame pulse; err_cnt saturating bad-frame count;
// timeout pulse on inter-byte timeout abort (only when DEBUG_FRAME_TIMEOUT_EN is defined, else tied 0).
module debug_frame_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 20'd250000,
  parameter int unsigned TO_BITS = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  r_data,
  input  logic        rx_empty,
  output logic        rd_uart,
  output logic [7:0]  set_addr,
  output logic [63:0] set_data,
  output logic        set_valid,
  output logic [7:0]  err_cnt,
  output logic        timeout
);
  typedef enum logic [1:0] {HUNT, ADDR, DATA, CHK} state_t;
  state_t      state_q;
  logic [2:0]  cnt_q;
  logic [7:0]  xor_q, addr_sh_q, set_addr_q, err_q;
  logic [63:0] data_sh_q, set_data_q;
  logic        set_valid_q;
  logic        pop;
  logic [7:0]  err_inc;
  assign pop = ~rx_empty;
  assign rd_uart = pop;
  assign err_inc = err_q == 8'hFF ? err_q : err_q + 8'd1;
  assign set_addr = set_addr_q;
  assign set_data = set_data_q;
  assign set_valid = set_valid_q;
  assign err_cnt = err_q;
`ifdef DEBUG_FRAME_TIMEOUT_EN
  logic [TO_BITS-1:0] to_q;
  logic               timeout_q;
  assign timeout = timeout_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT_CYCLES, TO_BITS};
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HUNT;
      cnt_q <= 3'd0;
      xor_q <= 8'd0;
      addr_sh_q <= 8'd0;
      data_sh_q <= 64'd0;
      set_addr_q <= 8'd0;
      set_data_q <= 64'd0;
      set_valid_q <= 1'b0;
      err_q <= 8'd0;
`ifdef DEBUG_FRAME_TIMEOUT_EN
      to_q <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      set_valid_q <= 1'b0;
      if (pop) begin
        case (state_q)
          HUNT: if (r_data == 8'hA5) state_q <= ADDR;
          ADDR: begin
            addr_sh_q <= r_data;
            xor_q <= r_data;
            cnt_q <= 3'd0;
            state_q <= DATA;
          end
          DATA: begin
            data_sh_q <= {data_sh_q[55:0], r_data};
            xor_q <= xor_q ^ r_data;
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_q <= CHK;
          end
          CHK: begin
            if (r_data == xor_q) begin
              set_addr_q <= addr_sh_q;
              set_data_q <= data_sh_q;
              set_valid_q <= 1'b1;
            end else err_q <= err_inc;
            state_q <= HUNT;
          end
        endcase
      end
`ifdef DEBUG_FRAME_TIMEOUT_EN
      timeout_q <= 1'b0;
      if (state_q == HUNT || pop) to_q <= '0;
      else if (to_q == TO_BITS'(TIMEOUT_CYCLES - 1)) begin
        to_q <= '0;
        state_q <= HUNT;
        err_q <= err_inc;
        timeout_q <= 1'b1;
      end else to_q <= to_q + TO_BITS'(1);
`endif
    end
  end
endmodule

// File: tb/tb_debug_frame_rx.sv
// tb_debug_frame_rx: randomized and directed frame stimulus checked against a frame-level reference model
module tb_debug_frame_rx;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  r_data = 8'd0;
  logic        rx_empty = 1'b1;
  logic        rd_uart;
  logic [7:0]  set_addr;
  logic [63:0] set_data;
  logic        set_valid;
  logic [7:0]  err_cnt;
  logic        timeout;
  int errors = 0, checks = 0, vcount = 0, tcount = 0, exp_vcount = 0, exp_tcount = 0;
  logic [7:0]  exp_addr = 8'd0, exp_err = 8'd0;
  logic [63:0] exp_data = 64'd0;
  debug_frame_rx #(.TIMEOUT_CYCLES(100), .TO_BITS(20)) dut (
    .clk(clk), .reset(reset), .r_data(r_data), .rx_empty(rx_empty), .rd_uart(rd_uart),
    .set_addr(set_addr), .set_data(set_data), .set_valid(set_valid), .err_cnt(err_cnt), .timeout(timeout)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (set_valid) vcount++;
    if (timeout) tcount++;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] xsum(input logic [7:0] a, input logic [63:0] d);
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) x ^= d[8*i +: 8];
    return x;
  endfunction
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return v == 8'hFF ? v : v + 8'd1;
  endfunction
  task automatic send_byte(input logic [7:0] b);
    r_data = b;
    rx_empty = 1'b0;
    #1 check("rd_uart_busy", rd_uart, 1);
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      rx_empty = 1'b1;
      #1 check("rd_uart_idle", rd_uart, 0);
      @(negedge clk);
    end
  endtask
  task automatic send_frame(input logic [7:0] a, input logic [63:0] d, input logic [7:0] c,
                            input int gapmax, input int chkgap);
    logic good;
    send_byte(8'hA5);
    send_byte(a);
    for (int i = 0; i < 8; i++) begin
      send_byte(d[63-8*i -: 8]);
      if (gapmax > 0) idle($urandom_range(0, gapmax));
    end
    idle(chkgap);
    send_byte(c);
    good = (c == xsum(a, d));
    if (good) begin
      exp_addr = a;
      exp_data = d;
      exp_vcount++;
    end else exp_err = sat_inc(exp_err);
    check("set_valid", set_valid, good);
    check("set_addr", set_addr, exp_addr);
    check("set_data", set_data, exp_data);
    check("err_cnt", err_cnt, exp_err);
  endtask
  initial begin
    logic [7:0]  a, c, g;
    logic [63:0] d;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_addr", set_addr, 0);
    check("rst_data", set_data, 0);
    check("rst_valid", set_valid, 0);
    check("rst_err", err_cnt, 0);
    check("rst_timeout", timeout, 0);
    send_frame(8'h01, 64'h0102030405060708, 8'h09, 0, 0);
    send_frame(8'h01, 64'h0102030405060708, 8'h0A, 0, 0);
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    send_frame(8'h02, 64'hA5A5A5A5A5A5A5A5, 8'h02, 0, 0);
    send_frame(8'h7E, 64'h0011223344556677, xsum(8'h7E, 64'h0011223344556677), 0, 0);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    reset = 1'b1;
    r_data = 8'hA5;
    rx_empty = 1'b0;
    #1 check("rd_uart_in_reset", rd_uart, 1);
    @(negedge clk);
    reset = 1'b0;
    rx_empty = 1'b1;
    exp_addr = 8'd0;
    exp_data = 64'd0;
    exp_err = 8'd0;
    check("mid_rst_addr", set_addr, 0);
    check("mid_rst_data", set_data, 0);
    check("mid_rst_valid", set_valid, 0);
    check("mid_rst_err", err_cnt, 0);
    send_frame(8'h11, 64'hDEADBEEFCAFEF00D, xsum(8'h11, 64'hDEADBEEFCAFEF00D), 0, 0);
`ifdef DEBUG_FRAME_TIMEOUT_EN
    send_byte(8'hA5);
    send_byte(8'h01);
    idle(99);
    check("timeout_early", timeout, 0);
    idle(1);
    check("timeout_pulse", timeout, 1);
    exp_err = sat_inc(exp_err);
    exp_tcount = 1;
    check("timeout_err", err_cnt, exp_err);
    idle(1);
    check("timeout_one_cycle", timeout, 0);
    send_frame(8'h22, 64'h8877665544332211, xsum(8'h22, 64'h8877665544332211), 0, 0);
`else
    send_frame(8'h33, 64'h0102030405060708, 8'h3B, 0, 150);
    check("no_timeout", timeout, 0);
`endif
    for (int n = 0; n < 40; n++) begin
      for (int k = $urandom_range(0, 3); k > 0; k--) begin
        g = 8'($urandom);
        send_byte(g == 8'hA5 ? 8'h00 : g);
      end
      a = 8'($urandom);
      d = {$urandom, $urandom};
      for (int i = 0; i < 8; i++) if ($urandom_range(0, 3) == 0) d[8*i +: 8] = 8'hA5;
      c = xsum(a, d);
      if ($urandom_range(0, 2) == 0) c ^= 8'($urandom_range(1, 255));
      send_frame(a, d, c, $urandom_range(0, 2), $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    for (int n = 0; n < 256; n++)
      send_frame(8'($urandom), 64'h0, 8'h5C ^ 8'h01, 0, 0);
    check("err_saturated", err_cnt, 8'hFF);
    send_frame(8'h00, 64'h0, 8'h01, 0, 0);
    check("err_stays_ff", err_cnt, 8'hFF);
    idle(3);
    check("valid_pulses", vcount, exp_vcount);
    check("timeout_pulses", tcount, exp_tcount);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
